// File: rtl/pipe_add_pkg.sv
// Shared types and saturation constants for the pipelined add/subtract unit.
package pipe_add_pkg;

    // Upper bound on WIDTH supported by the saturation constant helpers.
    localparam int unsigned MaxWidth = 64;

    // Control half of a pipeline stage record; operand slices ride in
    // per-stage vectors sized by the instantiating module.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
        logic sign;
        logic sat;
    } stage_ctrl_t;

    function automatic logic [MaxWidth-1:0] all_ones(input int unsigned width);
        logic [MaxWidth-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [MaxWidth-1:0] max_signed(input int unsigned width);
        logic [MaxWidth-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            if (i + 1 < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [MaxWidth-1:0] min_signed(input int unsigned width);
        logic [MaxWidth-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational WIDTH-bit adder slice with carry in and carry out.
module add_slice #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/pipe_add_sat.sv
// Pipelined add/subtract with carry split across STAGES, overflow flags and
// optional saturation; global stall driven by the output handshake.
module pipe_add_sat
    import pipe_add_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sign,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    localparam logic [MaxWidth-1:0] OnesFull = all_ones(WIDTH);
    localparam logic [MaxWidth-1:0] MaxSFull = max_signed(WIDTH);
    localparam logic [MaxWidth-1:0] MinSFull = min_signed(WIDTH);
    localparam logic [WIDTH-1:0]    SatOnes  = OnesFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SatMaxS  = MaxSFull[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SatMinS  = MinSFull[WIDTH-1:0];

    logic en;

    // Stage inputs: acc holds finished low slices and untouched high slices of a.
    logic [WIDTH-1:0] st_acc  [STAGES];
    logic [WIDTH-1:0] st_bx   [STAGES];
    stage_ctrl_t      st_ctrl [STAGES];

    logic [WIDTH-1:0] raw;
    logic             raw_cout;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ofl_q;
    logic             zero_q;

    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;

    assign st_acc[0]        = a;
    assign st_bx[0]         = sub ? ~b : b;
    assign st_ctrl[0].valid = in_valid;
    assign st_ctrl[0].carry = sub | cin;
    assign st_ctrl[0].sub   = sub;
    assign st_ctrl[0].sign  = sign;
    assign st_ctrl[0].sat   = sat;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned Lo = k * SLICE;

        logic [SLICE-1:0] slice_sum;
        logic             slice_cout;
        logic [WIDTH-1:0] acc_next;

        add_slice #(
            .WIDTH (SLICE)
        ) u_add_slice (
            .a    (st_acc[k][Lo +: SLICE]),
            .b    (st_bx[k][Lo +: SLICE]),
            .cin  (st_ctrl[k].carry),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        always_comb begin
            acc_next              = st_acc[k];
            acc_next[Lo +: SLICE] = slice_sum;
        end

        if (k < LAST) begin : g_reg
            logic [WIDTH-1:0] acc_q;
            logic [WIDTH-1:0] bx_q;
            stage_ctrl_t      ctrl_next;
            stage_ctrl_t      ctrl_q;

            always_comb begin
                ctrl_next       = st_ctrl[k];
                ctrl_next.carry = slice_cout;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q  <= '0;
                    bx_q   <= '0;
                    ctrl_q <= '0;
                end else if (en) begin
                    acc_q  <= acc_next;
                    bx_q   <= st_bx[k];
                    ctrl_q <= ctrl_next;
                end
            end

            assign st_acc[k+1]  = acc_q;
            assign st_bx[k+1]   = bx_q;
            assign st_ctrl[k+1] = ctrl_q;
        end else begin : g_last
            assign raw      = acc_next;
            assign raw_cout = slice_cout;
        end
    end

    stage_ctrl_t      fin;
    logic             a_msb;
    logic             bx_msb;
    logic             ofl_c;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] sum_c;

    // The last slice is still unadded, so its MSB is the original operand MSB.
    always_comb begin
        fin    = st_ctrl[LAST];
        a_msb  = st_acc[LAST][WIDTH-1];
        bx_msb = st_bx[LAST][WIDTH-1];

        if (fin.sign) begin
            ofl_c = (a_msb == bx_msb) && (raw[WIDTH-1] != a_msb);
        end else begin
            ofl_c = fin.sub ? ~raw_cout : raw_cout;
        end

        if (fin.sign) begin
            sat_val = a_msb ? SatMinS : SatMaxS;
        end else begin
            sat_val = fin.sub ? '0 : SatOnes;
        end

        sum_c = raw;
        if (SAT_EN && fin.sat && ofl_c) begin
            sum_c = sat_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ofl_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= fin.valid;
            if (fin.valid) begin
                sum_q  <= sum_c;
                cout_q <= raw_cout;
                ofl_q  <= ofl_c;
                zero_q <= ~|sum_c;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ofl       = ofl_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipe_add_sat.sv
// Directed bench for pipe_add_sat: a 16-bit/4-stage and an 8-bit/1-stage instance.
module tb_pipe_add_sat;

    typedef struct {
        logic        is8;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic        sign;
        logic        sat;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ofl;
        logic        exp_zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cin = 1'b0, sub = 1'b0, sign = 1'b0, sat = 1'b0;
    logic out_ready = 1'b1;

    logic        iv16 = 1'b0, ir16, ov16, cout16, ofl16, zero16;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        iv8 = 1'b0, ir8, ov8, cout8, ofl8, zero8;
    logic [7:0]  a8 = '0, b8 = '0, sum8;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_add_sat #(.WIDTH(16), .STAGES(4), .SAT_EN(1'b1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin), .sub(sub), .sign(sign), .sat(sat),
        .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(cout16),
        .ofl(ofl16), .zero(zero16)
    );

    pipe_add_sat #(.WIDTH(8), .STAGES(1), .SAT_EN(1'b1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin), .sub(sub), .sign(sign), .sat(sat),
        .out_valid(ov8), .out_ready(out_ready), .sum(sum8), .cout(cout8),
        .ofl(ofl8), .zero(zero8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat;
        logic ov;
        @(negedge clk);
        a16  = v.a;
        b16  = v.b;
        a8   = v.a[7:0];
        b8   = v.b[7:0];
        cin  = v.cin;
        sub  = v.sub;
        sign = v.sign;
        sat  = v.sat;
        if (v.is8) iv8 = 1'b1;
        else       iv16 = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", idx), v.is8 ? ir8 : ir16, 1);
        @(posedge clk);
        #1;
        iv8  = 1'b0;
        iv16 = 1'b0;
        lat  = 0;
        ov   = v.is8 ? ov8 : ov16;
        while (!ov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            ov = v.is8 ? ov8 : ov16;
        end
        check($sformatf("v%0d_latency", idx), lat, v.is8 ? 0 : 3);
        check($sformatf("v%0d_sum", idx), v.is8 ? {8'h00, sum8} : sum16, v.exp_sum);
        check($sformatf("v%0d_cout", idx), v.is8 ? cout8 : cout16, v.exp_cout);
        check($sformatf("v%0d_ofl", idx), v.is8 ? ofl8 : ofl16, v.exp_ofl);
        check($sformatf("v%0d_zero", idx), v.is8 ? zero8 : zero16, v.exp_zero);
    endtask

    vec_t vecs[14];

    initial begin
        int   sent, rcv, stale;
        logic fi, fo;

        //            is8   a         b         cin   sub   sign  sat   sum       cout  ofl   zero
        vecs[0]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h007F, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h007F, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid16", ov16, 0);
        check("rst_sum16", sum16, 0);
        check("rst_cout16", cout16, 0);
        check("rst_ofl16", ofl16, 0);
        check("rst_zero16", zero16, 0);
        check("rst_in_ready16", ir16, 1);
        check("rst_out_valid8", ov8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_in_ready8", ir8, 1);

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back stream of a=i, b=i with a three-cycle output stall.
        cin  = 1'b0;
        sub  = 1'b0;
        sign = 1'b0;
        sat  = 1'b0;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            iv16 = (sent < 8);
            a16  = 16'(sent);
            b16  = 16'(sent);
            #1;
            fi = iv16 & ir16;
            fo = ov16 & out_ready;
            if (ov16 && !out_ready) begin
                check("stall_in_ready", ir16, 0);
                check("stall_hold_sum", sum16, 32'(2 * rcv));
            end
            if (fo) begin
                check("stream_sum", sum16, 32'(2 * rcv));
            end
            @(posedge clk);
            if (fi) sent++;
            if (fo) rcv++;
        end
        iv16      = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 8);
        check("stream_received", rcv, 8);
        stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ov16) stale++;
        end
        check("stream_no_duplicate", stale, 0);

        // Reset with the first result visible and three more in flight.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            iv16 = 1'b1;
            a16  = 16'(k + 1);
            b16  = 16'h0000;
        end
        @(posedge clk);
        #1;
        check("pre_reset_valid", ov16, 1);
        check("pre_reset_sum", sum16, 1);
        rst_n = 1'b0;
        iv16  = 1'b0;
        #1;
        check("reset_out_valid", ov16, 0);
        check("reset_sum", sum16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ov16) stale++;
        end
        check("reset_no_stale", stale, 0);
        check("reset_in_ready", ir16, 1);
        run_vec(100, vecs[5]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
